data_cache: RTL
===============

Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the CPU load/store path (ALU result address, rs2 write data, MemWrite) and the backing data memory.
- Returns load hits combinationally in the same cycle. Stalls the CPU on load misses and on all stores until the memory handshake completes.

Parameters:
- DATA_WIDTH, 32, word width of CPU and memory data.
- ADDR_WIDTH, 32, byte address width.
- SETS, 8, number of one-word lines; power of two, at least 2. INDEX_BITS = log2(SETS).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- cpu_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- cpu_re  in  1  load request.
- cpu_we  in  1  store request.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_rdata  out  DATA_WIDTH  load data.
- cpu_stall  out  1  high means the CPU must hold PC and hold all cpu_* inputs stable.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write transaction, 0 = read transaction.
- mem_addr  out  ADDR_WIDTH  word-aligned memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data; valid when mem_ready is high.
- mem_ready  in  1  single-cycle completion pulse from memory.
- hit_count  out  32  load hit counter (see Optional Feature).
- miss_count  out  32  load miss counter (see Optional Feature).

Behaviour:
- Address split: index = cpu_addr[INDEX_BITS+1:2]; tag = cpu_addr[ADDR_WIDTH-1:INDEX_BITS+2].
- Storage per line: valid bit, tag, data word.
- Reset, synchronous: all valid bits cleared; state = IDLE; mem_req = 0, mem_we = 0; counters = 0; cpu_stall = 0 while idle. Data and tag arrays are not reset.
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE, load hit (cpu_re, valid, tag match):
  - cpu_rdata = line data; cpu_stall = 0; zero latency; stay in IDLE.
- IDLE, load miss:
  - cpu_stall = 1 combinationally in the same cycle; next state RD_MISS.
- IDLE, store (cpu_we):
  - cpu_stall = 1; next state WR_THRU.
  - If the line hits, its data is updated at this edge (write-update).
  - On a miss the line is left untouched (no allocate).
- cpu_we and cpu_re both high: treated as a store.
- Neither request asserted: cpu_stall = 0; cpu_rdata = 0.
- RD_MISS:
  - Outputs: mem_req = 1, mem_we = 0, mem_addr = {cpu_addr[ADDR_WIDTH-1:2], 2'b00}.
  - cpu_stall = ~mem_ready.
  - On mem_ready: cpu_rdata = mem_rdata in that cycle; at the edge the line is filled (valid = 1, tag, data); next state IDLE.
  - Miss latency = memory latency + 1 cycle.
- WR_THRU:
  - Outputs: mem_req = 1, mem_we = 1, mem_addr as in RD_MISS, mem_wdata = cpu_wdata.
  - cpu_stall = ~mem_ready.
  - On mem_ready: next state IDLE.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable from assertion until the cycle mem_ready is sampled high.
  - mem_req is low in the cycle after completion, so back-to-back misses always show at least one low cycle on mem_req.
  - mem_ready while in IDLE is ignored.
- Reset during RD_MISS or WR_THRU: the transaction is abandoned. mem_req is low from the next cycle and no line is filled; the memory model discards the orphan response.
- Index aliasing: a fill to an occupied index overwrites the line unconditionally; nothing is evicted because the cache is write-through.

Optional Feature:
- Macro: DATA_CACHE_STATS_EN.
- Defined:
  - hit_count increments on each IDLE load hit.
  - miss_count increments on each IDLE-to-RD_MISS transition.
  - Both wrap modulo 2^32; both cleared by rst.
- Undefined: hit_count and miss_count are tied to 0 and no counter flops are synthesised.

Decomposition:
- Package cache_pkg:
  - state enum (IDLE, RD_MISS, WR_THRU).
  - function computing INDEX_BITS and TAG_BITS from SETS and ADDR_WIDTH.
  - packed struct for a line {valid, tag, data}.
- Sub-module cache_line_store:
  - valid/tag/data arrays.
  - combinational read port.
  - one synchronous write port with separate fill and write-update enables.
  - synchronous valid clear on rst.
- data_cache contains the FSM, hit logic, memory-side muxing and optional counters.

Test Plan:
- Cold load: rst, then cpu_re at addr 0x0000_0010, memory latency 3, mem_rdata 0xDEAD_BEEF -> cpu_stall high for 3 cycles, mem_req with mem_addr 0x10, cpu_rdata 0xDEAD_BEEF on the mem_ready cycle, line valid afterwards.
- Warm hit: repeat the load at 0x10 -> cpu_stall 0, cpu_rdata 0xDEAD_BEEF same cycle, mem_req stays 0; with DATA_CACHE_STATS_EN, hit_count = 1 and miss_count = 1.
- Store hit: store 0x1234_5678 to 0x10 -> one write transaction with mem_we = 1 and mem_wdata 0x1234_5678; a later load of 0x10 hits and returns 0x1234_5678.
- Store miss no-allocate: store to 0x0000_0040 with the line empty -> memory written, then a load of 0x40 misses and issues a read.
- Aliasing: SETS = 8; load 0x04, then load 0x24 (same index, different tag), then load 0x04 -> three misses, three memory reads.
- Reset mid-miss: assert rst on the second cycle of RD_MISS -> mem_req low the next cycle, cpu_stall 0, the following load of the same address misses again.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped data cache.
// Line fields are sized for the widest supported geometry; narrower builds zero-pad.
package cache_pkg;

    localparam int CACHE_TAG_MAX  = 32;
    localparam int CACHE_DATA_MAX = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } cache_state_t;

    typedef struct packed {
        logic                      valid;
        logic [CACHE_TAG_MAX-1:0]  tag;
        logic [CACHE_DATA_MAX-1:0] data;
    } cache_line_t;

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int addr_width, input int sets);
        return addr_width - $clog2(sets) - 2;
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data storage for one-word lines: combinational read port, one
// synchronous write port (fill or data-only update), valid bits cleared by rst.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    output cache_line_t           rd_line,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic                  fill_en,
    input  logic                  update_en,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int SETS = 1 << INDEX_BITS;

    logic [SETS-1:0]       valid_reg;
    logic [TAG_BITS-1:0]   tag_mem  [SETS];
    logic [DATA_WIDTH-1:0] data_mem [SETS];

    genvar gi;
    generate
        for (gi = 0; gi < SETS; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (fill_en && (wr_index == INDEX_BITS'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Tag and data are deliberately not reset; a cleared valid bit masks them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end else if (update_en) begin
            data_mem[wr_index] <= wr_data;
        end
    end

    always_comb begin
        rd_line                       = '0;
        rd_line.valid                 = valid_reg[rd_index];
        rd_line.tag[TAG_BITS-1:0]     = tag_mem[rd_index];
        rd_line.data[DATA_WIDTH-1:0]  = data_mem[rd_index];
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with zero-latency load hits.
// Optional load hit/miss counters are built when DATA_CACHE_STATS_EN is defined.
module data_cache
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_re,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int INDEX_BITS = index_bits(SETS);
    localparam int TAG_BITS   = tag_bits(ADDR_WIDTH, SETS);

    cache_state_t state_reg, state_next;

    logic [INDEX_BITS-1:0]    cpu_index;
    logic [TAG_BITS-1:0]      cpu_tag;
    logic [CACHE_TAG_MAX-1:0] tag_ext;
    cache_line_t              rd_line;
    logic                     hit;
    logic                     fill_en;
    logic                     update_en;
    logic [DATA_WIDTH-1:0]    wr_data;

    assign cpu_index = cpu_addr[INDEX_BITS+1:2];
    assign cpu_tag   = cpu_addr[ADDR_WIDTH-1:INDEX_BITS+2];

    always_comb begin
        tag_ext                 = '0;
        tag_ext[TAG_BITS-1:0]   = cpu_tag;
    end

    assign hit = rd_line.valid && (rd_line.tag == tag_ext);

    // The CPU holds its inputs while stalled, so the request fields stay stable.
    assign mem_addr  = cpu_addr & ~ADDR_WIDTH'(3);
    assign mem_wdata = cpu_wdata;
    assign wr_data   = fill_en ? mem_rdata : cpu_wdata;

    cache_line_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (cpu_index),
        .rd_line   (rd_line),
        .wr_index  (cpu_index),
        .fill_en   (fill_en),
        .update_en (update_en),
        .wr_tag    (cpu_tag),
        .wr_data   (wr_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cpu_stall  = 1'b0;
        cpu_rdata  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        fill_en    = 1'b0;
        update_en  = 1'b0;
        case (state_reg)
            IDLE: begin
                // A store takes precedence over a simultaneous load.
                if (cpu_we) begin
                    cpu_stall  = 1'b1;
                    update_en  = hit;
                    state_next = WR_THRU;
                end else if (cpu_re) begin
                    if (hit) begin
                        cpu_rdata = rd_line.data[DATA_WIDTH-1:0];
                    end else begin
                        cpu_stall  = 1'b1;
                        state_next = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                mem_req   = 1'b1;
                cpu_stall = ~mem_ready;
                if (mem_ready) begin
                    cpu_rdata  = mem_rdata;
                    fill_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            WR_THRU: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                cpu_stall = ~mem_ready;
                if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_count_reg;
    logic [31:0] miss_count_reg;
    logic        hit_inc;
    logic        miss_inc;

    assign hit_inc  = (state_reg == IDLE) && !cpu_we && cpu_re && hit;
    assign miss_inc = (state_reg == IDLE) && !cpu_we && cpu_re && !hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (hit_inc) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            if (miss_inc) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
